// File: rtl/adder_entry_ctrl_if.sv
// Signal bundle between the operand-entry sequencer and the board:
// keys, switches and adder result in; operands, digit codes and status out.
interface adder_entry_ctrl_if;
    logic       key_a;
    logic       key_b;
    logic       key_cal;
    logic [3:0] sw_dig;
    logic [4:0] sum_in;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] dig_lt;
    logic [3:0] dig_rt;
    logic [2:0] state_o;
    logic       done;

    modport master (
        output key_a, key_b, key_cal, sw_dig, sum_in,
        input  op_a, op_b, dig_lt, dig_rt, state_o, done
    );

    modport slave (
        input  key_a, key_b, key_cal, sw_dig, sum_in,
        output op_a, op_b, dig_lt, dig_rt, state_o, done
    );
endinterface

// File: rtl/adder_entry_ctrl.sv
// Debounces the three entry keys, latches operands A/B for the adder, captures
// the sum after a settle window and drives the two decimal digit codes.
module adder_entry_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int CALC_WAIT = 2
) (
    input  logic                clk,
    input  logic                rst,
    adder_entry_ctrl_if.slave   bus
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int WW = (CALC_WAIT > 1) ? $clog2(CALC_WAIT) : 1;
    localparam logic [CW-1:0] DB_MAX    = CW'(DB_CYCLES);
    localparam logic [CW-1:0] DB_PRE    = CW'(DB_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(CALC_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HAVE_A = 3'd1,
        HAVE_B = 3'd2,
        CALC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    // Splits 0..30 into {tens, ones} digit codes without leading-zero blanking.
    function automatic logic [7:0] dec_split(input logic [4:0] v);
        logic [3:0] tens;
        logic [4:0] base;
        logic [4:0] ones;
        if (v >= 5'd30) begin
            tens = 4'd3;
            base = 5'd30;
        end else if (v >= 5'd20) begin
            tens = 4'd2;
            base = 5'd20;
        end else if (v >= 5'd10) begin
            tens = 4'd1;
            base = 5'd10;
        end else begin
            tens = 4'd0;
            base = 5'd0;
        end
        ones = v - base;
        return {tens, ones[3:0]};
    endfunction

    logic [2:0]    keys_s;
    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    logic [2:0]    armed_r;
    logic [2:0]    press_r;
    logic [CW-1:0] cnt_r [3];

    logic          press_a_s;
    logic          press_b_s;
    logic          press_cal_s;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          latch_a_s;
    logic          latch_b_s;
    logic          capture_s;

    logic [3:0]    op_a_r;
    logic [3:0]    op_b_r;
    logic [4:0]    sum_reg_r;
    logic [WW-1:0] wait_cnt_r;
    logic          done_r;
    logic [3:0]    dig_lt_r;
    logic [3:0]    dig_rt_r;

    logic [4:0]    disp_val_s;
    logic          disp_hold_s;
    logic [7:0]    split_s;

    assign keys_s = {bus.key_cal, bus.key_b, bus.key_a};

    // Key synchronizers and debouncers; sync flops reset to "pressed" so a key
    // held through reset never arms until it has been seen released.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            armed_r <= 3'b000;
            press_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_r <= keys_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i]) begin
                    cnt_r[i]   <= {CW{1'b0}};
                    armed_r[i] <= 1'b1;
                    press_r[i] <= 1'b0;
                end else if (cnt_r[i] != DB_MAX) begin
                    cnt_r[i]   <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
                    press_r[i] <= armed_r[i] && (cnt_r[i] == DB_PRE);
                    if (cnt_r[i] == DB_PRE) begin
                        armed_r[i] <= 1'b0;
                    end else begin
                        armed_r[i] <= armed_r[i];
                    end
                end else begin
                    press_r[i] <= 1'b0;
                end
            end
        end
    end

    assign press_a_s   = press_r[0];
    assign press_b_s   = press_r[1] & ~press_r[0];
    assign press_cal_s = press_r[2] & ~press_r[1] & ~press_r[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and operand/sum load decisions.
    always_comb begin
        state_nxt_s = state_r;
        latch_a_s   = 1'b0;
        latch_b_s   = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (press_a_s) begin
                    latch_a_s   = 1'b1;
                    state_nxt_s = HAVE_A;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HAVE_A: begin
                if (press_a_s) begin
                    latch_a_s   = 1'b1;
                    state_nxt_s = HAVE_A;
                end else if (press_b_s) begin
                    latch_b_s   = 1'b1;
                    state_nxt_s = HAVE_B;
                end else begin
                    state_nxt_s = HAVE_A;
                end
            end
            HAVE_B: begin
                if (press_a_s) begin
                    latch_a_s   = 1'b1;
                    state_nxt_s = HAVE_A;
                end else if (press_b_s) begin
                    latch_b_s   = 1'b1;
                    state_nxt_s = HAVE_B;
                end else if (press_cal_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = HAVE_B;
                end
            end
            CALC: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    capture_s   = 1'b1;
                    state_nxt_s = SHOW;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            SHOW: begin
                if (press_a_s) begin
                    latch_a_s   = 1'b1;
                    state_nxt_s = HAVE_A;
                end else begin
                    state_nxt_s = SHOW;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Display source per state; CALC freezes the digits at their last value.
    always_comb begin
        disp_val_s  = 5'd0;
        disp_hold_s = 1'b0;
        case (state_r)
            IDLE:    disp_val_s  = {1'b0, bus.sw_dig};
            HAVE_A:  disp_val_s  = {1'b0, op_a_r};
            HAVE_B:  disp_val_s  = {1'b0, op_b_r};
            CALC:    disp_hold_s = 1'b1;
            SHOW:    disp_val_s  = sum_reg_r;
            default: disp_val_s  = 5'd0;
        endcase
    end

    assign split_s = dec_split(disp_val_s);

    // Operand, sum, settle counter, done pulse and digit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r     <= 4'd0;
            op_b_r     <= 4'd0;
            sum_reg_r  <= 5'd0;
            wait_cnt_r <= {WW{1'b0}};
            done_r     <= 1'b0;
            dig_lt_r   <= 4'd10;
            dig_rt_r   <= 4'd10;
        end else begin
            if (latch_a_s) begin
                op_a_r <= bus.sw_dig;
            end else begin
                op_a_r <= op_a_r;
            end
            if (latch_b_s) begin
                op_b_r <= bus.sw_dig;
            end else begin
                op_b_r <= op_b_r;
            end
            if (capture_s) begin
                sum_reg_r <= bus.sum_in;
            end else begin
                sum_reg_r <= sum_reg_r;
            end
            if ((state_r == CALC) && !capture_s) begin
                wait_cnt_r <= wait_cnt_r + {{(WW-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_r <= {WW{1'b0}};
            end
            done_r <= capture_s;
            if (disp_hold_s) begin
                dig_lt_r <= dig_lt_r;
                dig_rt_r <= dig_rt_r;
            end else begin
                dig_lt_r <= split_s[7:4];
                dig_rt_r <= split_s[3:0];
            end
        end
    end

    assign bus.op_a    = op_a_r;
    assign bus.op_b    = op_b_r;
    assign bus.dig_lt  = dig_lt_r;
    assign bus.dig_rt  = dig_rt_r;
    assign bus.state_o = state_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_adder_entry_ctrl.sv
// Self-checking bench for adder_entry_ctrl: scoreboard of expected sums pushed
// when a compute is launched and popped when the done pulse appears.
module tb_adder_entry_ctrl;

    localparam int DB    = 4;
    localparam int CWAIT = 2;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] lt;
        logic [3:0] rt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    adder_entry_ctrl_if bus();

    adder_entry_ctrl #(.DB_CYCLES(DB), .CALC_WAIT(CWAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The 4-bit adder on the board.
    assign bus.sum_in = {1'b0, bus.op_a} + {1'b0, bus.op_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        if (k == 0) bus.key_a = 1'b0;
        else if (k == 1) bus.key_b = 1'b0;
        else bus.key_cal = 1'b0;
        tick(DB + 4);
        bus.key_a = 1'b1;
        bus.key_b = 1'b1;
        bus.key_cal = 1'b1;
        tick(3);
    endtask

    // Presses cal and watches done; edge index 0 is the first edge after the key falls.
    task automatic run_calc(output int done_cnt, output int done_k, output exp_t got);
        done_cnt = 0;
        done_k = -1;
        got = '{a: 4'd0, b: 4'd0, lt: 4'd0, rt: 4'd0};
        bus.key_cal = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == DB + 3) bus.key_cal = 1'b1;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_k = k;
                if (sb_q.size() > 0) got = sb_q.pop_front();
            end
        end
        tick(2);
    endtask

    task automatic test_reset();
        bus.key_a = 1'b1; bus.key_b = 1'b1; bus.key_cal = 1'b1; bus.sw_dig = 4'd0;
        rst = 1'b1;
        tick(2);
        n_cmp++; if (bus.op_a !== 4'd0) begin n_bad++; $display("FAIL reset_op_a got %0d want 0", bus.op_a); end
        n_cmp++; if (bus.op_b !== 4'd0) begin n_bad++; $display("FAIL reset_op_b got %0d want 0", bus.op_b); end
        n_cmp++; if (bus.dig_lt !== 4'd10 || bus.dig_rt !== 4'd10) begin n_bad++; $display("FAIL reset_digits got %0d/%0d want 10/10", bus.dig_lt, bus.dig_rt); end
        n_cmp++; if (bus.state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", bus.state_o); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", bus.done); end
        rst = 1'b0;
        bus.sw_dig = 4'd7;
        tick(1);
        n_cmp++; if (bus.dig_lt !== 4'd0 || bus.dig_rt !== 4'd7) begin n_bad++; $display("FAIL idle_live got %0d/%0d want 0/7", bus.dig_lt, bus.dig_rt); end
        tick(3);
    endtask

    task automatic test_basic_add();
        int dc, dk;
        exp_t e;
        bus.sw_dig = 4'd9;
        press(0);
        n_cmp++; if (bus.state_o !== 3'd1 || bus.op_a !== 4'd9) begin n_bad++; $display("FAIL latch_a got state %0d op_a %0d want 1/9", bus.state_o, bus.op_a); end
        n_cmp++; if (bus.dig_lt !== 4'd0 || bus.dig_rt !== 4'd9) begin n_bad++; $display("FAIL show_a got %0d/%0d want 0/9", bus.dig_lt, bus.dig_rt); end
        bus.sw_dig = 4'd6;
        press(1);
        n_cmp++; if (bus.state_o !== 3'd2 || bus.op_b !== 4'd6) begin n_bad++; $display("FAIL latch_b got state %0d op_b %0d want 2/6", bus.state_o, bus.op_b); end
        n_cmp++; if (bus.dig_lt !== 4'd0 || bus.dig_rt !== 4'd6) begin n_bad++; $display("FAIL show_b got %0d/%0d want 0/6", bus.dig_lt, bus.dig_rt); end
        sb_q.push_back('{a: 4'd9, b: 4'd6, lt: 4'd1, rt: 4'd5});
        run_calc(dc, dk, e);
        n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", dc); end
        n_cmp++; if (dk !== DB + 2 + CWAIT) begin n_bad++; $display("FAIL basic_done_edge got %0d want %0d", dk, DB + 2 + CWAIT); end
        n_cmp++; if (bus.op_a !== e.a || bus.op_b !== e.b) begin n_bad++; $display("FAIL basic_ops got %0d+%0d want %0d+%0d", bus.op_a, bus.op_b, e.a, e.b); end
        n_cmp++; if (bus.dig_lt !== e.lt || bus.dig_rt !== e.rt) begin n_bad++; $display("FAIL basic_sum got %0d/%0d want %0d/%0d", bus.dig_lt, bus.dig_rt, e.lt, e.rt); end
        n_cmp++; if (bus.state_o !== 3'd4) begin n_bad++; $display("FAIL basic_show got %0d want 4", bus.state_o); end
    endtask

    task automatic test_max_and_zero();
        int dc, dk;
        exp_t e;
        bus.sw_dig = 4'd15; press(0);
        n_cmp++; if (bus.dig_lt !== 4'd1 || bus.dig_rt !== 4'd5) begin n_bad++; $display("FAIL show_a15 got %0d/%0d want 1/5", bus.dig_lt, bus.dig_rt); end
        press(1);
        sb_q.push_back('{a: 4'd15, b: 4'd15, lt: 4'd3, rt: 4'd0});
        run_calc(dc, dk, e);
        n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL max_done_count got %0d want 1", dc); end
        n_cmp++; if (bus.op_a !== e.a || bus.op_b !== e.b) begin n_bad++; $display("FAIL max_ops got %0d+%0d want %0d+%0d", bus.op_a, bus.op_b, e.a, e.b); end
        n_cmp++; if (bus.dig_lt !== e.lt || bus.dig_rt !== e.rt) begin n_bad++; $display("FAIL max_sum got %0d/%0d want %0d/%0d", bus.dig_lt, bus.dig_rt, e.lt, e.rt); end
        bus.sw_dig = 4'd4; press(1); press(2);
        n_cmp++; if (bus.state_o !== 3'd4 || bus.op_b !== 4'd15 || bus.dig_rt !== 4'd0) begin n_bad++; $display("FAIL show_ignore got state %0d op_b %0d rt %0d want 4/15/0", bus.state_o, bus.op_b, bus.dig_rt); end
        bus.sw_dig = 4'd0; press(0); press(1);
        sb_q.push_back('{a: 4'd0, b: 4'd0, lt: 4'd0, rt: 4'd0});
        run_calc(dc, dk, e);
        n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL zero_done_count got %0d want 1", dc); end
        n_cmp++; if (bus.dig_lt !== e.lt || bus.dig_rt !== e.rt || bus.state_o !== 3'd4) begin n_bad++; $display("FAIL zero_sum got %0d/%0d state %0d want %0d/%0d state 4", bus.dig_lt, bus.dig_rt, bus.state_o, e.lt, e.rt); end
    endtask

    task automatic test_bounce();
        bus.sw_dig = 4'd5;
        bus.key_a = 1'b0; tick(3);
        bus.key_a = 1'b1; tick(1);
        bus.key_a = 1'b0; tick(3);
        bus.key_a = 1'b1; tick(10);
        n_cmp++; if (bus.state_o !== 3'd4 || bus.op_a !== 4'd0) begin n_bad++; $display("FAIL bounce got state %0d op_a %0d want 4/0", bus.state_o, bus.op_a); end
    endtask

    task automatic test_hold();
        bus.sw_dig = 4'd3;
        bus.key_a = 1'b0;
        tick(DB + 6);
        bus.sw_dig = 4'd11;
        tick(50 - (DB + 6));
        bus.key_a = 1'b1;
        tick(3);
        n_cmp++; if (bus.state_o !== 3'd1 || bus.op_a !== 4'd3) begin n_bad++; $display("FAIL hold_one_pulse got state %0d op_a %0d want 1/3", bus.state_o, bus.op_a); end
        n_cmp++; if (bus.dig_lt !== 4'd0 || bus.dig_rt !== 4'd3) begin n_bad++; $display("FAIL hold_digits got %0d/%0d want 0/3", bus.dig_lt, bus.dig_rt); end
    endtask

    task automatic test_priority();
        int dc;
        dc = 0;
        bus.sw_dig = 4'd8; press(1);
        n_cmp++; if (bus.state_o !== 3'd2) begin n_bad++; $display("FAIL prio_setup got state %0d want 2", bus.state_o); end
        bus.sw_dig = 4'd12;
        bus.key_a = 1'b0; bus.key_cal = 1'b0;
        for (int k = 0; k < DB + 10; k++) begin
            tick(1);
            if (bus.done === 1'b1 || bus.state_o === 3'd3) dc++;
        end
        bus.key_a = 1'b1; bus.key_cal = 1'b1;
        tick(3);
        n_cmp++; if (dc !== 0) begin n_bad++; $display("FAIL prio_no_calc got %0d calc cycles want 0", dc); end
        n_cmp++; if (bus.state_o !== 3'd1 || bus.op_a !== 4'd12) begin n_bad++; $display("FAIL prio_a got state %0d op_a %0d want 1/12", bus.state_o, bus.op_a); end
        n_cmp++; if (bus.dig_lt !== 4'd1 || bus.dig_rt !== 4'd2) begin n_bad++; $display("FAIL prio_digits got %0d/%0d want 1/2", bus.dig_lt, bus.dig_rt); end
    endtask

    task automatic test_reset_mid_calc();
        bit reached;
        int dc;
        reached = 1'b0;
        dc = 0;
        bus.sw_dig = 4'd2; press(1);
        bus.key_cal = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            tick(1);
            if (bus.state_o === 3'd3) reached = 1'b1;
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL calc_reach timeout state %0d want 3", bus.state_o); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp++; if (bus.state_o !== 3'd0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL midcalc_rst got state %0d done %0b want 0/0", bus.state_o, bus.done); end
        n_cmp++; if (bus.dig_lt !== 4'd10 || bus.dig_rt !== 4'd10 || bus.op_a !== 4'd0) begin n_bad++; $display("FAIL midcalc_out got %0d/%0d op_a %0d want 10/10/0", bus.dig_lt, bus.dig_rt, bus.op_a); end
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (bus.done === 1'b1) dc++;
        end
        bus.key_cal = 1'b1;
        n_cmp++; if (dc !== 0) begin n_bad++; $display("FAIL midcalc_done got %0d pulses want 0", dc); end
    endtask

    task automatic test_key_held_reset();
        bus.key_a = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        bus.sw_dig = 4'd6;
        tick(20);
        n_cmp++; if (bus.state_o !== 3'd0 || bus.op_a !== 4'd0) begin n_bad++; $display("FAIL held_rst got state %0d op_a %0d want 0/0", bus.state_o, bus.op_a); end
        bus.key_a = 1'b1;
        tick(3);
        press(0);
        n_cmp++; if (bus.state_o !== 3'd1 || bus.op_a !== 4'd6) begin n_bad++; $display("FAIL held_rearm got state %0d op_a %0d want 1/6", bus.state_o, bus.op_a); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        test_reset();
        test_basic_add();
        test_max_and_zero();
        test_bounce();
        test_hold();
        test_priority();
        test_reset_mid_calc();
        test_key_held_reset();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d entries want 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_entry_ctrl.md
# adder_entry_ctrl

Operand-entry and compute sequencer for the 4-bit adder datapath on the board. It debounces the three push keys, latches operand A and operand B from the 4-bit switch bank, and presents both operands to the adder. It then captures the adder's 5-bit result after a settle window and drives the two 7-segment digit codes, which feed the existing segment lookup, with the live switch value, the operand being entered, or the decimal sum.

## Interface
- DB_CYCLES, 16: consecutive synchronized-low clock edges required before a key press is accepted (≥2)
- CALC_WAIT, 2: cycles between entering CALC and capturing sum_in (≥1)
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- key_a  in  1  raw key, active-low: latch operand A
- key_b  in  1  raw key, active-low: latch operand B
- key_cal  in  1  raw key, active-low: compute
- sw_dig  in  4  switch value, 0..15
- sum_in  in  5  adder result {carry, sum}, 0..30, combinational from op_a/op_b
- op_a  out  4  operand A to adder; reset 0
- op_b  out  4  operand B to adder; reset 0
- dig_lt  out  4  tens digit code (0..9, 10 = dash); reset 10
- dig_rt  out  4  ones digit code; reset 10
- state_o  out  3  current state encoding; reset 0
- done  out  1  one-cycle pulse when the sum is captured; reset 0

## Operation
- Each key passes through a 2-flop synchronizer, then a debouncer: a counter increments on each edge where the synced key is low and clears when it is high. When the count reaches DB_CYCLES, the press pulse is high for exactly one cycle. No further pulse is produced until the synced key is high for ≥1 edge (re-arm).
- Debouncers leave reset disarmed. A key held through reset never produces a pulse until it is released.
- Same-cycle presses use priority a > b > cal. Lower-priority pulses in that cycle are discarded.
- States: IDLE=0, HAVE_A=1, HAVE_B=2, CALC=3, SHOW=4.
  - IDLE: display sw_dig live. press_a latches op_a←sw_dig and moves to HAVE_A. press_b and press_cal are ignored.
  - HAVE_A: display op_a. press_a re-latches op_a. press_b latches op_b←sw_dig and moves to HAVE_B. press_cal is ignored.
  - HAVE_B: display op_b. press_a re-latches op_a and moves to HAVE_A. press_b re-latches op_b. press_cal moves to CALC.
  - CALC: the display holds its previous value and all presses are ignored. After CALC_WAIT cycles, sum_reg←sum_in, done=1, and the FSM moves to SHOW.
  - SHOW: display sum_reg. press_a latches op_a and moves to HAVE_A. press_b and press_cal are ignored; the result stays until A is re-entered.
- Decimal split for value v (0..30): v≥30 gives tens 3; v≥20 gives tens 2; v≥10 gives tens 1; otherwise tens 0. Ones = v − 10·tens. No leading-zero blanking. Operands 10..15 display as "1","0".."1","5".
- dig_lt and dig_rt are registered, recomputed every cycle from the state's display source.

## Timing
- Let the key fall before edge 0 and stay low. The synced low is first sampled at edge 2. The press pulse is high after edge DB_CYCLES+1. The state and op_* update at edge DB_CYCLES+2. The digits update at edge DB_CYCLES+3.
- In IDLE, a sw_dig change appears on the digits 1 cycle later. sw_dig is not synchronized; the switches are static.
- CALC entered at edge t: capture and SHOW at edge t+CALC_WAIT. done is high during cycle t+CALC_WAIT to t+CALC_WAIT+1. The digits show the sum from edge t+CALC_WAIT+1.
- rst dominates everything, including a pending pulse or mid-CALC. All outputs and counters return to reset values at that edge, and sum_reg is cleared to 0.

## Test plan
- Reset, DB_CYCLES=4: outputs are op_a=0, op_b=0, dig=10/10, state_o=0, done=0. With sw_dig=7 after reset, the display is 0/7 one cycle later.
- sw=9, press A; sw=6, press B; press cal → op_a=9, op_b=6, after CALC_WAIT: done pulse, digits 1/5, state_o=4.
- Max case 15+15 with carry: sum_in=30 → digits 3/0. Case 0+0 → 0/0, and done still pulses.
- Bounce: key low for 3 cycles, high 1, low 3 with DB_CYCLES=4 → no pulse, state unchanged. Holding a key 50 cycles → exactly one pulse.
- key_a and key_cal pressed in the same cycle while in HAVE_B → op_a re-latched, state HAVE_A, no CALC.
- rst asserted mid-CALC → next cycle state_o=0, digits 10/10, no done pulse. A key held across reset yields no pulse until released and pressed again.
